// File: rtl/irq_pkg.sv
// Shared constants, types and helpers for the interrupt pending/service slice.
package irq_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } irq_state_t;

    typedef logic [N_REQ-1:0] req_vec_t;

    function automatic req_vec_t idx_onehot(input logic [IDX_W-1:0] idx);
        idx_onehot = req_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/irq_cap_cell.sv
// One request line: set-event detection, sticky pending bit and overflow flag.
// IRQ_EDGE_DETECT_EN selects rising-edge capture; otherwise the line is level-sensitive.
module irq_cap_cell (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic clr,
    input  logic ovf_clr,
    output logic pend,
    output logic ovf
);

    logic set_ev;

`ifdef IRQ_EDGE_DETECT_EN
    logic req_q;

    always_ff @(posedge clk) begin
        if (rst) req_q <= 1'b0;
        else     req_q <= req;
    end

    assign set_ev = req & ~req_q;

    // An event landing on an already pending line is lost unless the line is being serviced now.
    always_ff @(posedge clk) begin
        if (rst)                        ovf <= 1'b0;
        else if (set_ev && pend && !clr) ovf <= 1'b1;
        else if (ovf_clr)               ovf <= 1'b0;
    end
`else
    logic unused_ovf_clr;

    assign set_ev         = req;
    assign ovf            = 1'b0;
    assign unused_ovf_clr = ovf_clr;
`endif

    // Set has priority over the service clear so a fresh request is never dropped.
    always_ff @(posedge clk) begin
        if (rst)         pend <= 1'b0;
        else if (set_ev) pend <= 1'b1;
        else if (clr)    pend <= 1'b0;
    end

endmodule

// File: rtl/irq_pend_ctrl.sv
// Pending-request capture plus valid/ready offer of the externally encoded index.
// Build option IRQ_EDGE_DETECT_EN (see irq_cap_cell) selects edge capture with overflow flags.
//
//   state | meaning
//   IDLE  | no offer outstanding; load encoder result when any line is pending
//   OFFER | req_idx held on req_valid until the consumer takes it
module irq_pend_ctrl
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_in,
    output logic [N_REQ-1:0] pend,
    input  logic [IDX_W-1:0] enc_y,
    input  logic             enc_v,
    output logic             req_valid,
    output logic [IDX_W-1:0] req_idx,
    input  logic             req_ready,
    output logic [N_REQ-1:0] ovf,
    input  logic [N_REQ-1:0] ovf_clr
);

    irq_state_t       state, state_nxt;
    logic             valid_nxt;
    logic [IDX_W-1:0] idx_nxt;
    req_vec_t         clr_vec;

    for (genvar i = 0; i < N_REQ; i++) begin : g_cell
        irq_cap_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .req     (req_in[i]),
            .clr     (clr_vec[i]),
            .ovf_clr (ovf_clr[i]),
            .pend    (pend[i]),
            .ovf     (ovf[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_valid <= 1'b0;
            req_idx   <= '0;
        end else begin
            state     <= state_nxt;
            req_valid <= valid_nxt;
            req_idx   <= idx_nxt;
        end
    end

    // Returning to IDLE after a handshake gives the mandatory one-cycle bubble between offers.
    always_comb begin
        state_nxt = state;
        valid_nxt = req_valid;
        idx_nxt   = req_idx;
        clr_vec   = '0;
        case (state)
            IDLE: begin
                if (enc_v) begin
                    idx_nxt   = enc_y;
                    valid_nxt = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (req_valid && req_ready) begin
                    clr_vec   = idx_onehot(req_idx);
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Directed bench for irq_pend_ctrl with a behavioural 4->2 encoder and an index scoreboard.
module tb_irq_pend_ctrl;
    import irq_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_REQ-1:0] req_in;
    logic [N_REQ-1:0] pend;
    logic [IDX_W-1:0] enc_y;
    logic             enc_v;
    logic             req_valid;
    logic [IDX_W-1:0] req_idx;
    logic             req_ready;
    logic [N_REQ-1:0] ovf;
    logic [N_REQ-1:0] ovf_clr;

    int n_pass  = 0;
    int n_total = 0;
    logic [IDX_W-1:0] exp_q[$];

    irq_pend_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .pend      (pend),
        .enc_y     (enc_y),
        .enc_v     (enc_v),
        .req_valid (req_valid),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    // Highest set index wins.
    always_comb begin
        enc_v = |pend;
        enc_y = '0;
        for (int i = 0; i < N_REQ; i++)
            if (pend[i]) enc_y = 2'(i);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each accepted offer must match the next expected index.
    always @(negedge clk) begin
        if (!rst && req_valid && req_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_handshake", 32'(req_idx), 32'hFF);
            end else begin
                chk("sb_idx", 32'(req_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    logic [N_REQ-1:0] exp_ovf2;

    initial begin
`ifdef IRQ_EDGE_DETECT_EN
        exp_ovf2 = 4'b0100;
`else
        exp_ovf2 = 4'b0000;
`endif
        rst = 1'b1; req_in = 4'hF; req_ready = 1'b0; ovf_clr = '0;
        tick(); tick();
        chk("rst_pend", 32'(pend), 32'h0);
        chk("rst_valid", 32'(req_valid), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        rst = 1'b0; req_in = '0;
        tick(); tick();
        chk("idle_valid", 32'(req_valid), 32'h0);

        // single request
        req_in = 4'b0010; req_ready = 1'b1; exp_q.push_back(2'd1);
        tick(); req_in = '0;
        chk("single_pend", 32'(pend), 32'h2);
        chk("single_valid_n1", 32'(req_valid), 32'h0);
        tick();
        chk("single_valid", 32'(req_valid), 32'h1);
        chk("single_idx", 32'(req_idx), 32'h1);
        tick();
        chk("single_clr", 32'(pend), 32'h0);
        chk("single_drop", 32'(req_valid), 32'h0);

        // priority + stall
        req_ready = 1'b0; req_in = 4'b0101;
        exp_q.push_back(2'd2); exp_q.push_back(2'd0);
        tick(); req_in = '0;
        chk("prio_pend", 32'(pend), 32'h5);
        tick();
        chk("prio_idx", 32'(req_idx), 32'h2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_valid", 32'(req_valid), 32'h1);
            chk("stall_idx", 32'(req_idx), 32'h2);
        end
        req_ready = 1'b1;
        tick();
        chk("bubble_valid", 32'(req_valid), 32'h0);
        chk("bubble_pend", 32'(pend), 32'h1);
        tick();
        chk("prio2_valid", 32'(req_valid), 32'h1);
        chk("prio2_idx", 32'(req_idx), 32'h0);
        tick();
        chk("prio2_clr", 32'(pend), 32'h0);

        // freeze
        req_ready = 1'b0; req_in = 4'b0001;
        exp_q.push_back(2'd0); exp_q.push_back(2'd3);
        tick(); req_in = '0;
        tick();
        chk("frz_idx0", 32'(req_idx), 32'h0);
        req_in = 4'b1000;
        tick(); req_in = '0;
        chk("frz_pend", 32'(pend), 32'h9);
        chk("frz_idx1", 32'(req_idx), 32'h0);
        tick();
        chk("frz_idx2", 32'(req_idx), 32'h0);
        req_ready = 1'b1;
        tick();
        chk("frz_pend3", 32'(pend), 32'h8);
        chk("frz_bubble", 32'(req_valid), 32'h0);
        tick();
        chk("frz_next_idx", 32'(req_idx), 32'h3);
        tick();
        chk("frz_clr", 32'(pend), 32'h0);

        // set vs clear on the same line
        req_ready = 1'b0; req_in = 4'b0010;
        exp_q.push_back(2'd1); exp_q.push_back(2'd1);
        tick(); req_in = '0;
        tick();
        chk("svc_offer", 32'(req_idx), 32'h1);
        req_ready = 1'b1; req_in = 4'b0010;
        tick(); req_in = '0;
        chk("svc_pend_kept", 32'(pend), 32'h2);
        chk("svc_ovf", 32'(ovf), 32'h0);
        chk("svc_bubble", 32'(req_valid), 32'h0);
        tick();
        chk("svc_reoffer_v", 32'(req_valid), 32'h1);
        chk("svc_reoffer_idx", 32'(req_idx), 32'h1);
        tick();
        chk("svc_clr", 32'(pend), 32'h0);

        // overflow
        req_ready = 1'b0; req_in = 4'b0100;
        tick(); req_in = '0;
        tick();
        req_in = 4'b0100;
        tick(); req_in = '0;
        chk("ovf_set", 32'(ovf), 32'(exp_ovf2));
        tick();
        chk("ovf_sticky", 32'(ovf), 32'(exp_ovf2));
        ovf_clr = 4'b0100;
        tick(); ovf_clr = '0;
        chk("ovf_clr", 32'(ovf), 32'h0);
        req_ready = 1'b1; exp_q.push_back(2'd2);
        tick();
        chk("ovf_drain", 32'(pend), 32'h0);
        req_ready = 1'b0;

        // reset while offering
        req_in = 4'b1000;
        tick(); req_in = '0;
        tick();
        chk("rmo_valid", 32'(req_valid), 32'h1);
        rst = 1'b1;
        tick();
        chk("rmo_valid_rst", 32'(req_valid), 32'h0);
        chk("rmo_pend_rst", 32'(pend), 32'h0);
        chk("rmo_idx_rst", 32'(req_idx), 32'h0);
        rst = 1'b0;
        tick(); tick();
        chk("rmo_quiet", 32'(req_valid), 32'h0);

        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
